// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller for the 5-stage core.
// Turns hazard, redirect and halt requests into per-stage enables. It also
// arbitrates the data-memory bus with the DMA engine by cycle stealing, and
// keeps saturating stall/flush counters for performance debug.
module pipeline_stall_controller #(
  parameter int CNT_W     = 16,
  parameter int GRANT_DLY = 1    // 1..3 idle cycles before the grant
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_hazard,
  input  logic             id_jump,
  input  logic             ex_mispredict,
  input  logic             id_halt,
  input  logic             mem_busy,
  input  logic             dma_br,
  output logic             dma_bg,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic       {RUN, HALT} runState_t;
  typedef enum logic [1:0] {BUS_IDLE, BUS_WAIT, BUS_GRANT} busState_t;

  localparam logic [1:0] WAIT_RELOAD = 2'(GRANT_DLY - 1);

  runState_t  runState, runNext;
  busState_t  busState, busNext;
  logic [1:0] waitCnt, waitNext;

  // State registers; dma_bg and halted are flops so they drop straight off reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      runState <= RUN;
      busState <= BUS_IDLE;
      waitCnt  <= '0;
      dma_bg   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      runState <= runNext;
      busState <= busNext;
      waitCnt  <= waitNext;
      dma_bg   <= (busNext == BUS_GRANT);
      halted   <= (runNext == HALT);
    end
  end

  // Bus arbitration: the DMA only gets the bus after GRANT_DLY consecutive
  // cycles in which MEM leaves it idle; any MEM access restarts the wait.
  always_comb begin
    busNext  = busState;
    waitNext = waitCnt;
    case (busState)
      BUS_IDLE: begin
        if (dma_br) begin
          busNext  = BUS_WAIT;
          waitNext = WAIT_RELOAD;
        end
      end
      BUS_WAIT: begin
        if (!dma_br)               busNext  = BUS_IDLE;
        else if (mem_busy)         waitNext = WAIT_RELOAD;
        else if (waitCnt == 2'd0)  busNext  = BUS_GRANT;
        else                       waitNext = waitCnt - 2'd1;
      end
      BUS_GRANT: begin
        if (!dma_br) busNext = BUS_IDLE;
      end
      default: busNext = BUS_IDLE;
    endcase
  end

  // MEM wants the bus while the DMA owns it: everything past ID must hold.
  assign pipe_freeze = (busState == BUS_GRANT) && mem_busy;

  // Stage control, strict priority: freeze, mispredict, hazard, jump, halt.
  always_comb begin
    runNext      = runState;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (runState == HALT) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (pipe_freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end else if (ex_mispredict) begin
      // ID holds a wrong-path instruction, so its hazard/jump/halt is moot.
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (data_hazard) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (id_jump) begin
      if_id_flush = 1'b1;
    end else if (id_halt) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      runNext     = HALT;
    end
  end

  // Saturating performance counters; halted cycles are not stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (runState == RUN && !pc_write && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (if_id_flush && flush_events != '1)
        flush_events <= flush_events + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances (grant delay 1 and 3,
// 4-bit counters) share stimulus and are compared every cycle against a
// behavioural model; table vectors and directed sequences cover the corners.
module tb_pipeline_stall_controller;

  localparam int CW = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic dh = 0, jmp = 0, mis = 0, hlt = 0, busy = 0, br = 0;

  logic          bgO[2], pcO[2], ifidO[2], flO[2], bubO[2], frzO[2], hltO[2];
  logic [CW-1:0] stallO[2], flushO[2];

  int nCmp = 0;
  int nErr = 0;

  // model state
  bit mHalted[2], mReq[2], mGrant[2];
  int mIdleRun[2], mStall[2], mFlush[2];
  int dly[2] = '{1, 3};

  always #5 clk = ~clk;

  pipeline_stall_controller #(.CNT_W(CW), .GRANT_DLY(1)) dutA (
    .clk(clk), .reset_n(resetN), .data_hazard(dh), .id_jump(jmp),
    .ex_mispredict(mis), .id_halt(hlt), .mem_busy(busy), .dma_br(br),
    .dma_bg(bgO[0]), .pc_write(pcO[0]), .if_id_write(ifidO[0]),
    .if_id_flush(flO[0]), .id_ex_bubble(bubO[0]), .pipe_freeze(frzO[0]),
    .halted(hltO[0]), .stall_cycles(stallO[0]), .flush_events(flushO[0]));

  pipeline_stall_controller #(.CNT_W(CW), .GRANT_DLY(3)) dutB (
    .clk(clk), .reset_n(resetN), .data_hazard(dh), .id_jump(jmp),
    .ex_mispredict(mis), .id_halt(hlt), .mem_busy(busy), .dma_br(br),
    .dma_bg(bgO[1]), .pc_write(pcO[1]), .if_id_write(ifidO[1]),
    .if_id_flush(flO[1]), .id_ex_bubble(bubO[1]), .pipe_freeze(frzO[1]),
    .halted(hltO[1]), .stall_cycles(stallO[1]), .flush_events(flushO[1]));

  typedef struct {
    bit dh, jmp, mis, hlt;
    bit pc, ifid, fl, bub;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(string nm, int act, int exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected combinational outputs {pc, ifid, flush, bubble, freeze}.
  function automatic logic [4:0] expOut(int i);
    logic frz;
    frz = mGrant[i] & busy;
    if (mHalted[i]) return {4'b0001, frz};
    if (frz)        return 5'b00001;
    if (mis)        return 5'b11110;
    if (dh)         return 5'b00010;
    if (jmp)        return 5'b11100;
    if (hlt)        return 5'b00000;
    return 5'b11000;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      mHalted[i] = 0; mReq[i] = 0; mGrant[i] = 0;
      mIdleRun[i] = 0; mStall[i] = 0; mFlush[i] = 0;
    end
  endtask

  task automatic checkAll();
    logic [4:0] e;
    for (int i = 0; i < 2; i++) begin
      e = expOut(i);
      chk($sformatf("pc_write[%0d]", i), pcO[i], e[4]);
      chk($sformatf("if_id_write[%0d]", i), ifidO[i], e[3]);
      chk($sformatf("if_id_flush[%0d]", i), flO[i], e[2]);
      chk($sformatf("id_ex_bubble[%0d]", i), bubO[i], e[1]);
      chk($sformatf("pipe_freeze[%0d]", i), frzO[i], e[0]);
      chk($sformatf("dma_bg[%0d]", i), bgO[i], mGrant[i]);
      chk($sformatf("halted[%0d]", i), hltO[i], mHalted[i]);
      chk($sformatf("stall_cycles[%0d]", i), stallO[i], mStall[i]);
      chk($sformatf("flush_events[%0d]", i), flushO[i], mFlush[i]);
    end
  endtask

  // Model advance for one clock edge with the current inputs.
  task automatic updateModel();
    logic [4:0] e;
    for (int i = 0; i < 2; i++) begin
      e = expOut(i);
      if (!mHalted[i]) begin
        if (!e[4] && mStall[i] < SAT) mStall[i]++;
        if (e[2] && mFlush[i] < SAT)  mFlush[i]++;
        if (!e[0] && !mis && !dh && !jmp && hlt) mHalted[i] = 1;
      end
      // grant after dly[i] consecutive idle-bus cycles of a held request
      if (mGrant[i]) begin
        if (!br) mGrant[i] = 0;
      end else if (mReq[i]) begin
        if (!br) mReq[i] = 0;
        else if (busy) mIdleRun[i] = 0;
        else begin
          mIdleRun[i]++;
          if (mIdleRun[i] == dly[i]) begin
            mGrant[i] = 1;
            mReq[i] = 0;
          end
        end
      end else if (br) begin
        mReq[i] = 1;
        mIdleRun[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    checkAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic clrIn();
    dh = 0; jmp = 0; mis = 0; hlt = 0; busy = 0; br = 0;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    resetModel();
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  initial begin
    vecs[0] = '{0,0,0,0, 1,1,0,0};
    vecs[1] = '{1,0,0,0, 0,0,0,1};
    vecs[2] = '{0,1,0,0, 1,1,1,0};
    vecs[3] = '{0,0,1,0, 1,1,1,1};
    vecs[4] = '{1,0,1,0, 1,1,1,1};
    vecs[5] = '{1,1,0,0, 0,0,0,1};
    vecs[6] = '{0,0,0,1, 0,0,0,0};
    vecs[7] = '{1,0,0,1, 0,0,0,1};
    vecs[8] = '{0,1,0,1, 1,1,1,0};
    vecs[9] = '{0,0,1,1, 1,1,1,1};

    resetModel();
    clrIn();
    #3;
    chk("reset dma_bg", bgO[0], 0);
    chk("reset pc_write", pcO[0], 1);
    chk("reset halted", hltO[0], 0);
    @(posedge clk);
    #1 resetN = 1'b1;

    // table vectors, from reset each
    for (int v = 0; v < 10; v++) begin
      clrIn();
      doReset();
      dh = vecs[v].dh; jmp = vecs[v].jmp; mis = vecs[v].mis; hlt = vecs[v].hlt;
      #1;
      chk($sformatf("vec%0d pc_write", v), pcO[0], vecs[v].pc);
      chk($sformatf("vec%0d if_id_write", v), ifidO[0], vecs[v].ifid);
      chk($sformatf("vec%0d if_id_flush", v), flO[0], vecs[v].fl);
      chk($sformatf("vec%0d id_ex_bubble", v), bubO[0], vecs[v].bub);
      step();
      chk($sformatf("vec%0d halted", v), hltO[0], vecs[v].hlt & ~vecs[v].dh & ~vecs[v].jmp & ~vecs[v].mis);
    end

    // T2: three hazard cycles -> three stall cycles
    clrIn(); doReset();
    dh = 1;
    repeat (3) step();
    dh = 0;
    chk("T2 stall_cycles", stallO[0], 3);
    step();
    chk("T2 pc_write after clear", pcO[0], 1);

    // T3: mispredict beats hazard
    clrIn(); doReset();
    dh = 1; mis = 1; #1;
    chk("T3 if_id_flush", flO[0], 1);
    chk("T3 id_ex_bubble", bubO[0], 1);
    chk("T3 pc_write", pcO[0], 1);
    step();
    chk("T3 flush_events", flushO[0], 1);
    chk("T3 stall_cycles", stallO[0], 0);

    // T4: grant timing (delay 1) and freeze
    clrIn(); doReset();
    br = 1; busy = 1;
    step();
    step();
    busy = 0;
    chk("T4 dma_bg before idle edge", bgO[0], 0);
    step();
    chk("T4 dma_bg after idle edge", bgO[0], 1);
    chk("T4 dly3 dma_bg not yet", bgO[1], 0);
    busy = 1; #1;
    chk("T4 pipe_freeze", frzO[0], 1);
    chk("T4 pc_write frozen", pcO[0], 0);
    chk("T4 dly3 pipe_freeze", frzO[1], 0);
    step();
    br = 0;
    step();
    chk("T4 dma_bg dropped", bgO[0], 0);

    // T1: async reset mid-grant with mem_busy high
    clrIn(); doReset();
    dh = 1; step(); dh = 0; jmp = 1; step(); jmp = 0;
    br = 1;
    repeat (5) step();
    busy = 1; #1;
    chk("T1 pipe_freeze before reset", frzO[1], 1);
    resetN = 1'b0; #1;
    chk("T1 dma_bg", bgO[1], 0);
    chk("T1 pipe_freeze", frzO[1], 0);
    chk("T1 halted", hltO[1], 0);
    chk("T1 stall_cycles", stallO[0], 0);
    chk("T1 flush_events", flushO[0], 0);
    resetModel(); clrIn();
    @(posedge clk); #1 resetN = 1'b1;

    // T5: halt deferred by hazard, sticky, DMA still served
    clrIn(); doReset();
    hlt = 1; dh = 1;
    repeat (2) step();
    chk("T5 no halt under hazard", hltO[0], 0);
    dh = 0;
    step();
    chk("T5 halted", hltO[0], 1);
    hlt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("T5 halted hold %0d", k), hltO[0], 1);
    end
    br = 1;
    repeat (5) step();
    chk("T5 dma_bg in halt", bgO[0], 1);
    chk("T5 dly3 dma_bg in halt", bgO[1], 1);
    chk("T5 stall not counted", stallO[0], 3);

    // T6: counter saturation
    clrIn(); doReset();
    dh = 1;
    repeat (20) step();
    chk("T6 stall_cycles saturate", stallO[0], SAT);
    dh = 0;

    // randomized traffic against the model
    clrIn(); doReset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) br = ~br;
      busy = $urandom_range(0, 1);
      dh   = ($urandom_range(0, 3) == 0);
      jmp  = ($urandom_range(0, 6) == 0);
      mis  = ($urandom_range(0, 9) == 0);
      hlt  = ($urandom_range(0, 99) == 0);
      if ((mHalted[0] && $urandom_range(0, 19) == 0) || $urandom_range(0, 299) == 0)
        doReset();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
